int_to_float: RTL

INT_TO_FLOAT -- requirements
Module: int_to_float

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fp_round.sv | 38 +++
 rtl/int_to_float.sv | 83 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and FSM state type for the integer-to-float converter.
package fpu_pkg;

  localparam int EXP_W          = 8;
  localparam int FRAC_W         = 23;
  localparam int FP_BIAS        = 127;
  localparam int FP_EXP_INT_MAX = FP_BIAS + 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_round.sv
// Combinational rounding/packing of a normalised magnitude into a single-precision float.
// INT_TO_FLOAT_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_round
  import fpu_pkg::*;
(
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [31:0]      mag_i,
  output logic [31:0]      float_o
);

`ifdef INT_TO_FLOAT_RNE_EN
  localparam bit RneEn = 1'b1;
`else
  localparam bit RneEn = 1'b0;
`endif

  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              inc;
  logic [FRAC_W+1:0] sum;
  logic [FRAC_W-1:0] frac;
  logic [EXP_W-1:0]  expOut;

  // Hidden bit is kept in the sum so a carry-out lands in the top bit and renormalises by one.
  always_comb begin
    guard   = mag_i[7];
    sticky  = |mag_i[6:0];
    lsb     = mag_i[8];
    inc     = RneEn & guard & (sticky | lsb);
    sum     = {1'b0, mag_i[31], mag_i[30:8]} + {{(FRAC_W+1){1'b0}}, inc};
    frac    = sum[FRAC_W+1] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    expOut  = exp_i + {{(EXP_W-1){1'b0}}, sum[FRAC_W+1]};
    float_o = {sign_i, expOut, frac};
  end

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle 32-bit integer to IEEE 754 single conversion: one-bit-per-cycle normalise, then round.
// Rounding mode is chosen in fp_round by the INT_TO_FLOAT_RNE_EN macro.
module int_to_float
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_int,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float,
  output logic        busy
);

  state_e           state_q;
  logic             sign_q;
  logic [31:0]      mag_q;
  logic [EXP_W-1:0] exp_q;
  logic [31:0]      result_q;
  logic             accSign;
  logic [31:0]      roundFloat;

  assign accSign   = in_signed & in_int[31];
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_float = result_q;

  fp_round u_round (
    .sign_i  (sign_q),
    .exp_i   (exp_q),
    .mag_i   (mag_q),
    .float_o (roundFloat)
  );

  // result_q is only nonzero while in DONE, so out_float reads zero whenever out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= accSign;
            mag_q   <= accSign ? (32'd0 - in_int) : in_int;
            exp_q   <= EXP_W'(FP_EXP_INT_MAX);
            state_q <= NORM;
          end
        end
        NORM: begin
          if (mag_q == 32'd0) begin
            result_q <= '0;
            state_q  <= DONE;
          end else if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 1'b1;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q <= roundFloat;
          state_q  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            result_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
